// File: rtl/counter_modulo_n.sv
`default_nettype none
// ============================================================================
// Module   : counter_modulo_n
// Purpose  : Up/down modulo-N counter with synchronous load, optional
//            saturation at the limits, a zero-latency terminal indicator, a
//            one-cycle limit pulse and a sticky limit flag.
// Ports    : clock_pos      - clock, state updates on rising edge
//            reset_neg      - asynchronous active-low reset
//            bit_enable     - count enable
//            bit_up         - direction (1 = up, 0 = down)
//            bit_load       - synchronous load strobe (beats enable)
//            vector_load    - load value, clamped to MODULUS-1
//            bit_clear_flag - synchronous clear of bit_overflow
//            vector_out     - registered count, always in 0..MODULUS-1
//            bit_terminal   - count is at the limit for current direction
//            bit_wrap       - pulse in the cycle after a limit event
//            bit_overflow   - sticky limit-event flag
// Revision : 1.0 - initial release
// ============================================================================
module counter_modulo_n #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic             clock_pos,
    input  logic             reset_neg,
    input  logic             bit_enable,
    input  logic             bit_up,
    input  logic             bit_load,
    input  logic [WIDTH-1:0] vector_load,
    input  logic             bit_clear_flag,
    output logic [WIDTH-1:0] vector_out,
    output logic             bit_terminal,
    output logic             bit_wrap,
    output logic             bit_overflow
);

    // MODULUS may equal 2^WIDTH, so MODULUS-1 always fits in WIDTH bits while
    // MODULUS itself might not; the load clamp compares at 32 bits instead.
    localparam logic [WIDTH-1:0] c_MAX   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_ZERO  = '0;
    localparam logic [WIDTH-1:0] c_ONE   = WIDTH'(1);
    localparam logic [31:0]      c_MOD32 = 32'(MODULUS);
    localparam logic             c_SAT   = (SATURATE != 0);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_overflow;

    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_load_val;
    logic [31:0]      w_load_ext;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_terminal;
    logic             w_limit;

    assign w_at_max   = (r_count == c_MAX);
    assign w_at_zero  = (r_count == c_ZERO);
    assign w_terminal = bit_up ? w_at_max : w_at_zero;

    // A limit event covers both a real wrap and a blocked saturating step;
    // a load edge never counts as one.
    assign w_limit    = bit_enable & ~bit_load & w_terminal;

    assign w_load_ext = 32'(vector_load);
    assign w_load_val = (w_load_ext < c_MOD32) ? vector_load : c_MAX;

    always_comb begin
        w_count_nxt = r_count;
        if (bit_load) begin
            w_count_nxt = w_load_val;
        end else if (bit_enable) begin
            if (bit_up) begin
                if (w_at_max) begin
                    w_count_nxt = c_SAT ? c_MAX : c_ZERO;
                end else begin
                    w_count_nxt = r_count + c_ONE;
                end
            end else begin
                if (w_at_zero) begin
                    w_count_nxt = c_SAT ? c_ZERO : c_MAX;
                end else begin
                    w_count_nxt = r_count - c_ONE;
                end
            end
        end
    end

    always_ff @(posedge clock_pos or negedge reset_neg) begin
        if (!reset_neg) begin
            r_count    <= c_ZERO;
            r_wrap     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_wrap  <= w_limit;
            // Set has priority over clear when both land on the same edge.
            if (w_limit) begin
                r_overflow <= 1'b1;
            end else if (bit_clear_flag) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign vector_out   = r_count;
    assign bit_terminal = w_terminal;
    assign bit_wrap     = r_wrap;
    assign bit_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_counter_modulo_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_modulo_n
// Purpose  : Self-checking bench for counter_modulo_n. Three instances share
//            one stimulus stream: MODULUS=10 wrapping, MODULUS=10 saturating
//            and MODULUS=16 wrapping. A modular-arithmetic reference model
//            predicts every output and is compared on each falling edge;
//            directed scenarios pin both model and DUT to literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_modulo_n;

    localparam int c_N = 3;

    logic       clock_pos      = 1'b0;
    logic       reset_neg      = 1'b1;
    logic       bit_enable     = 1'b0;
    logic       bit_up         = 1'b0;
    logic       bit_load       = 1'b0;
    logic [3:0] vector_load    = 4'd0;
    logic       bit_clear_flag = 1'b0;

    logic [3:0] w_out  [c_N];
    logic       w_term [c_N];
    logic       w_wrap [c_N];
    logic       w_ovf  [c_N];

    int  c_mod [c_N] = '{10, 10, 16};
    bit  c_sat [c_N] = '{1'b0, 1'b1, 1'b0};

    int  m_cnt  [c_N] = '{0, 0, 0};
    bit  m_wrap [c_N] = '{1'b0, 1'b0, 1'b0};
    bit  m_ovf  [c_N] = '{1'b0, 1'b0, 1'b0};

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  chk_en  = 1'b0;

    always #5 clock_pos = ~clock_pos;

    counter_modulo_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_dut_wrap (
        .clock_pos(clock_pos), .reset_neg(reset_neg), .bit_enable(bit_enable),
        .bit_up(bit_up), .bit_load(bit_load), .vector_load(vector_load),
        .bit_clear_flag(bit_clear_flag), .vector_out(w_out[0]),
        .bit_terminal(w_term[0]), .bit_wrap(w_wrap[0]), .bit_overflow(w_ovf[0])
    );

    counter_modulo_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_dut_sat (
        .clock_pos(clock_pos), .reset_neg(reset_neg), .bit_enable(bit_enable),
        .bit_up(bit_up), .bit_load(bit_load), .vector_load(vector_load),
        .bit_clear_flag(bit_clear_flag), .vector_out(w_out[1]),
        .bit_terminal(w_term[1]), .bit_wrap(w_wrap[1]), .bit_overflow(w_ovf[1])
    );

    counter_modulo_n #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_dut_p2 (
        .clock_pos(clock_pos), .reset_neg(reset_neg), .bit_enable(bit_enable),
        .bit_up(bit_up), .bit_load(bit_load), .vector_load(vector_load),
        .bit_clear_flag(bit_clear_flag), .vector_out(w_out[2]),
        .bit_terminal(w_term[2]), .bit_wrap(w_wrap[2]), .bit_overflow(w_ovf[2])
    );

    // Reference model: the count lives on a ring of c_mod values, so a step
    // is (count +/- 1) mod N, except a saturating instance refuses to step
    // off the end it is already sitting on.
    always @(posedge clock_pos or negedge reset_neg) begin : model
        int top;
        int nxt;
        bit lim;
        if (!reset_neg) begin
            for (int k = 0; k < c_N; k++) begin
                m_cnt[k]  <= 0;
                m_wrap[k] <= 1'b0;
                m_ovf[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < c_N; k++) begin
                top = c_mod[k] - 1;
                lim = bit_enable && !bit_load &&
                      (bit_up ? (m_cnt[k] == top) : (m_cnt[k] == 0));
                if (bit_load)
                    nxt = (int'(vector_load) < c_mod[k]) ? int'(vector_load) : top;
                else if (bit_enable && lim && c_sat[k])
                    nxt = m_cnt[k];
                else if (bit_enable)
                    nxt = (m_cnt[k] + (bit_up ? 1 : -1) + c_mod[k]) % c_mod[k];
                else
                    nxt = m_cnt[k];
                m_cnt[k]  <= nxt;
                m_wrap[k] <= lim;
                m_ovf[k]  <= lim || (m_ovf[k] && !bit_clear_flag);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Pins both the DUT and the model of instance k to hand-computed values.
    task automatic pin(input string tag, input int k, input int c, input int w, input int o);
        chk($sformatf("%s[%0d].count", tag, k), int'(w_out[k]), c);
        chk($sformatf("%s[%0d].wrap", tag, k), int'(w_wrap[k]), w);
        chk($sformatf("%s[%0d].ovf", tag, k), int'(w_ovf[k]), o);
        chk($sformatf("%s[%0d].model_count", tag, k), m_cnt[k], c);
        chk($sformatf("%s[%0d].model_wrap", tag, k), int'(m_wrap[k]), w);
        chk($sformatf("%s[%0d].model_ovf", tag, k), int'(m_ovf[k]), o);
    endtask

    // Continuous comparison, mid-cycle, away from the active edge.
    always @(negedge clock_pos) begin
        if (chk_en) begin
            for (int k = 0; k < c_N; k++) begin
                chk($sformatf("cyc[%0d].count", k), int'(w_out[k]), m_cnt[k]);
                chk($sformatf("cyc[%0d].terminal", k), int'(w_term[k]),
                    int'(bit_up ? (m_cnt[k] == c_mod[k] - 1) : (m_cnt[k] == 0)));
                chk($sformatf("cyc[%0d].wrap", k), int'(w_wrap[k]), int'(m_wrap[k]));
                chk($sformatf("cyc[%0d].ovf", k), int'(w_ovf[k]), int'(m_ovf[k]));
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock_pos);
            #2;
        end
    endtask

    initial begin
        #1 reset_neg = 1'b0;
        chk_en = 1'b1;
        tick(2);
        for (int k = 0; k < c_N; k++) pin("reset", k, 0, 0, 0);

        // Up-count wrap from 0.
        reset_neg = 1'b1; bit_enable = 1'b1; bit_up = 1'b1;
        tick(9);
        pin("up9", 0, 9, 0, 0);
        chk("up9.terminal", int'(w_term[0]), 1);
        tick(1);
        pin("up10", 0, 0, 1, 1);
        pin("up10", 1, 9, 1, 1);
        pin("up10", 2, 10, 0, 0);
        tick(2);
        pin("up12", 0, 2, 0, 1);
        pin("up12", 1, 9, 1, 1);
        pin("up12", 2, 12, 0, 0);

        // Load 0 then count down twice.
        bit_load = 1'b1; vector_load = 4'd0;
        tick(1);
        pin("ld0", 0, 0, 0, 1);
        bit_load = 1'b0; bit_up = 1'b0;
        tick(1);
        pin("dn1", 0, 9, 1, 1);
        pin("dn1", 1, 0, 1, 1);
        pin("dn1", 2, 15, 1, 1);
        tick(1);
        pin("dn2", 0, 8, 0, 1);
        pin("dn2", 1, 0, 1, 1);
        pin("dn2", 2, 14, 0, 1);

        // Saturation: load 8 then up three times.
        bit_load = 1'b1; vector_load = 4'd8;
        tick(1);
        bit_load = 1'b0; bit_up = 1'b1;
        tick(3);
        pin("sat", 1, 9, 1, 1);
        pin("sat", 0, 1, 0, 1);
        pin("sat", 2, 11, 0, 1);

        // Clear, clamped load, then clear colliding with a limit event.
        bit_enable = 1'b0; bit_clear_flag = 1'b1;
        tick(1);
        pin("clr", 0, 1, 0, 0);
        bit_clear_flag = 1'b0; bit_load = 1'b1; vector_load = 4'd13; bit_enable = 1'b1;
        tick(1);
        pin("clamp", 0, 9, 0, 0);
        pin("clamp", 1, 9, 0, 0);
        pin("clamp", 2, 13, 0, 0);
        bit_load = 1'b0; bit_clear_flag = 1'b1;
        tick(1);
        pin("setwins", 0, 0, 1, 1);
        pin("setwins", 1, 9, 1, 1);
        pin("setwins", 2, 14, 0, 0);

        // Asynchronous reset in the middle of a cycle at count 5.
        bit_clear_flag = 1'b0; bit_load = 1'b1; vector_load = 4'd4;
        tick(1);
        bit_load = 1'b0;
        tick(1);
        pin("pre_rst", 0, 5, 0, 1);
        reset_neg = 1'b0;
        #1;
        for (int k = 0; k < c_N; k++) pin("async_rst", k, 0, 0, 0);
        tick(1);
        reset_neg = 1'b1;
        tick(1);
        pin("resume", 0, 1, 0, 0);

        // Power-of-two modulus: natural rollover both ways.
        bit_load = 1'b1; vector_load = 4'd15;
        tick(1);
        pin("ld15", 2, 15, 0, 0);
        pin("ld15", 0, 9, 0, 0);
        bit_load = 1'b0;
        tick(1);
        pin("p2up", 2, 0, 1, 1);
        pin("p2up", 0, 0, 1, 1);
        bit_up = 1'b0;
        tick(1);
        pin("p2dn", 2, 15, 1, 1);
        pin("p2dn", 0, 9, 1, 1);

        // Randomized traffic, with occasional mid-cycle reset pulses.
        for (int i = 0; i < 400; i++) begin
            reset_neg      = ($urandom_range(0, 49) != 0);
            bit_enable     = ($urandom_range(0, 3) != 0);
            bit_up         = 1'($urandom_range(0, 1));
            bit_load       = ($urandom_range(0, 7) == 0);
            vector_load    = 4'($urandom_range(0, 15));
            bit_clear_flag = ($urandom_range(0, 15) == 0);
            tick(1);
        end
        reset_neg = 1'b1;
        tick(2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
